// File: rtl/matrix_scan_driver.sv
// Row-at-a-time scan driver for an 8x8 RGB matrix behind a 32-bit 74HC595 chain.
// Each row: load a shift word, clock it out MSB first, latch it, then display it for a fixed dwell.
module matrix_scan_driver #(
  parameter int CLK_DIV        = 2,
  parameter int DWELL          = 100,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0][23:0] frame,
  output logic             ds,
  output logic             sh_cp,
  output logic             st_cp,
  output logic             oe_n,
  output logic [2:0]       row_idx,
  output logic             frame_done
);

  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int DWELL_W = $clog2(DWELL + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DWELLING} state_t;

  state_t               state, state_nxt;
  logic [7:0][23:0]     snap, snap_nxt;
  logic [31:0]          word, word_nxt;
  logic [5:0]           bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0]     div_cnt, div_cnt_nxt;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_cnt_nxt;
  logic                 ds_nxt, sh_cp_nxt, st_cp_nxt, oe_n_nxt, frame_done_nxt;
  logic [2:0]           row_nxt;
  logic [23:0]          row_data;
  logic [31:0]          load_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      word       <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      dwell_cnt  <= '0;
      ds         <= 1'b0;
      sh_cp      <= 1'b0;
      st_cp      <= 1'b0;
      oe_n       <= 1'b1;
      row_idx    <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      snap       <= snap_nxt;
      word       <= word_nxt;
      bit_cnt    <= bit_cnt_nxt;
      div_cnt    <= div_cnt_nxt;
      dwell_cnt  <= dwell_cnt_nxt;
      ds         <= ds_nxt;
      sh_cp      <= sh_cp_nxt;
      st_cp      <= st_cp_nxt;
      oe_n       <= oe_n_nxt;
      row_idx    <= row_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    snap_nxt       = snap;
    word_nxt       = word;
    bit_cnt_nxt    = bit_cnt;
    div_cnt_nxt    = div_cnt;
    dwell_cnt_nxt  = dwell_cnt;
    ds_nxt         = ds;
    sh_cp_nxt      = sh_cp;
    st_cp_nxt      = st_cp;
    oe_n_nxt       = oe_n;
    row_nxt        = row_idx;
    frame_done_nxt = 1'b0;

    // Row 0 reads the live frame because the snapshot is only being written this cycle.
    row_data  = (row_idx == 3'd0) ? frame[0] : snap[row_idx];
    load_word = {8'(1) << row_idx, COL_ACTIVE_LOW ? ~row_data : row_data};

    case (state)
      IDLE: begin
        oe_n_nxt = 1'b1;
        if (enable) state_nxt = LOAD;
      end
      LOAD: begin
        if (row_idx == 3'd0) snap_nxt = frame;
        word_nxt    = load_word;
        ds_nxt      = load_word[31];
        bit_cnt_nxt = 6'd0;
        div_cnt_nxt = '0;
        sh_cp_nxt   = 1'b0;
        oe_n_nxt    = 1'b1;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_nxt = div_cnt + 1'b1;
        end else begin
          div_cnt_nxt = '0;
          if (!sh_cp) begin
            sh_cp_nxt = 1'b1;
          end else begin
            sh_cp_nxt = 1'b0;
            if (bit_cnt == 6'd31) begin
              st_cp_nxt = 1'b1;
              state_nxt = LATCH;
            end else begin
              word_nxt    = word << 1;
              ds_nxt      = word[30];
              bit_cnt_nxt = bit_cnt + 6'd1;
            end
          end
        end
      end
      LATCH: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_nxt = div_cnt + 1'b1;
        end else begin
          div_cnt_nxt   = '0;
          st_cp_nxt     = 1'b0;
          oe_n_nxt      = 1'b0;
          dwell_cnt_nxt = '0;
          state_nxt     = DWELLING;
        end
      end
      DWELLING: begin
        if (dwell_cnt != DWELL_LAST) begin
          dwell_cnt_nxt = dwell_cnt + 1'b1;
        end else begin
          // row_idx wraps 7 -> 0 naturally, in the same cycle as frame_done.
          dwell_cnt_nxt  = '0;
          oe_n_nxt       = 1'b1;
          frame_done_nxt = (row_idx == 3'd7);
          row_nxt        = row_idx + 3'd1;
          state_nxt      = enable ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
- Consumes the 8-row x 24-bit RGB frame produced by the smiley/pattern generator. Row layout is [23:16] = R, [15:8] = G, [7:0] = B, one bit per column.
- Scans the 8x8 RGB LED matrix one row at a time. Each row is shifted serially into an external 32-bit daisy-chain of 74HC595-style shift registers (8 row-select bits, then 24 colour bits), latched, then displayed for a fixed dwell time.
- The frame is snapshotted once per frame, so a generator update mid-scan never tears the image.

Parameters:
- CLK_DIV, 2: clk cycles per shift-clock phase. Each serial bit takes 2*CLK_DIV cycles. Legal range is 1 or more.
- DWELL, 100: clk cycles each row is displayed (oe_n low). Legal range is 1 or more.
- COL_ACTIVE_LOW, 1: when 1, the 24 colour bits are inverted before shifting (common-anode matrix, cathodes sink).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- enable, input, 1: start or continue scanning.
- frame, input, [7:0][23:0]: frame from the pattern generator; frame[r] is row r.
- ds, output, 1: serial data to the shift-register chain.
- sh_cp, output, 1: shift clock. The chain samples ds on the rising edge.
- st_cp, output, 1: storage/latch clock. The chain transfers on the rising edge.
- oe_n, output, 1: output enable, active-low.
- row_idx, output, 3: row currently loaded, shifting or displayed.
- frame_done, output, 1: one-cycle pulse at the end of row 7's dwell.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, ds=0, sh_cp=0, st_cp=0, oe_n=1, row_idx=0, frame_done=0, all counters 0. Reset mid-operation aborts immediately; there is no partial latch.
- All outputs are registered.
- States: IDLE, LOAD, SHIFT, LATCH, DWELL.
- IDLE: oe_n=1. Moves to LOAD when enable=1.
- LOAD (1 cycle):
  - If row_idx==0, copy the whole frame into the internal snapshot.
  - Build the 32-bit shift word {8'b1<<row_idx, COL_ACTIVE_LOW ? ~snap[row_idx] : snap[row_idx]}, using the new snapshot when row_idx==0.
  - Set bit counter to 0. oe_n=1.
- SHIFT: 32 bits, MSB first.
  - For each bit: ds = current MSB and sh_cp=0 for CLK_DIV cycles, then sh_cp=1 for CLK_DIV cycles.
  - The word shifts left when sh_cp returns low.
  - ds is stable through the entire high phase. oe_n stays 1.
  - After the 32nd high phase: sh_cp=0, go to LATCH.
- LATCH: st_cp=1 for CLK_DIV cycles, then st_cp=0, go to DWELL.
- DWELL: oe_n=0 for exactly DWELL cycles, then oe_n=1. Then:
  - If row_idx==7: pulse frame_done for 1 cycle and wrap row_idx to 0.
  - Otherwise: increment row_idx.
  - Next state is LOAD if enable=1, else IDLE.
- Row period is 1 + 64*CLK_DIV + CLK_DIV + DWELL cycles. With defaults this is 231 cycles; a frame is 1848 cycles.
- enable deasserted mid-row: the current row completes (SHIFT/LATCH/DWELL), then the block enters IDLE with oe_n=1. row_idx keeps the next row, so scanning resumes from there, not from row 0.
- The frame input is sampled only in LOAD with row_idx==0. Changes at any other time take effect on the next frame.
- Counter widths: bit counter 6 bits; div counter $clog2(CLK_DIV+1); dwell counter $clog2(DWELL+1). No overflow is possible within the legal parameter ranges.
- frame_done and row-7-to-0 wrap in the same cycle is the normal case. frame_done is never asserted for more than 1 cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with enable=1 -> ds=0, sh_cp=0, st_cp=0, oe_n=1, row_idx=0, frame_done=0. No sh_cp edges until the cycle after rst_n=1.
- Single row: frame[0]=24'h003C00, COL_ACTIVE_LOW=0, defaults -> 32 sh_cp rising edges. The captured ds stream is 0x01003C00. st_cp is high for 2 cycles, then oe_n low for exactly 100 cycles. Row period is 231 cycles.
- Inversion: COL_ACTIVE_LOW=1, frame[3]=24'hFF0000 -> captured word 0x0800FFFF (row bits not inverted).
- Full frame: free-run with enable=1 -> row_idx steps 0..7. frame_done pulses once every 1848 cycles, coinciding with the 7->0 wrap.
- Tear-free: change frame while row_idx=4 -> rows 4..7 still show the old snapshot; the new data appears from row 0 of the next frame.
- Enable drop and mid-shift reset:
  - Deassert enable during row 2 SHIFT -> row 2 completes its dwell, IDLE with oe_n=1, row_idx=3; re-enable -> resumes at row 3.
  - Assert rst_n=0 mid-SHIFT -> st_cp is never pulsed and the next scan starts at row 0.
